// File: rtl/mult_div_unit_if.sv
// Handshake and result bundle of the iterative multiply/divide unit.
// The abort signal exists only when MDU_ABORT_EN is defined.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] RegA_out;
   logic [WIDTH-1:0] RegB_out;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;
   logic             divide_by_zero;
`ifdef MDU_ABORT_EN
   logic             abort;

   modport master (
      output start, op, RegA_out, RegB_out, abort,
      input  busy, done, Hi, Lo, divide_by_zero
   );
   modport slave (
      input  start, op, RegA_out, RegB_out, abort,
      output busy, done, Hi, Lo, divide_by_zero
   );
`else
   modport master (
      output start, op, RegA_out, RegB_out,
      input  busy, done, Hi, Lo, divide_by_zero
   );
   modport slave (
      input  start, op, RegA_out, RegB_out,
      output busy, done, Hi, Lo, divide_by_zero
   );
`endif
endinterface

// File: rtl/mult_div_unit.sv
// Iterative Booth multiply / restoring divide with Hi/Lo result registers.
// Optional abort of a running operation when MDU_ABORT_EN is defined.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic          clock,
   input  logic          Reset,
   mult_div_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH:0]   m_q, m_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             qm1_q, qm1_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fixa_q, fixa_d;
   logic             fixb_q, fixb_d;
   logic             dz_q, dz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             abort_w;
   logic             accept;
   logic             in_div, in_sgn, a_neg, b_neg, b_zero;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   booth_sum, shl, diff;
   logic [WIDTH-1:0] mul_hi, div_hi, div_lo;

`ifdef MDU_ABORT_EN
   assign abort_w = bus.abort;
`else
   assign abort_w = 1'b0;
`endif

   assign accept = bus.start & (state_q != CALC);
   assign in_div = bus.op[1];
   assign in_sgn = ~bus.op[0];
   assign a_neg  = in_sgn & bus.RegA_out[WIDTH-1];
   assign b_neg  = in_sgn & bus.RegB_out[WIDTH-1];
   assign b_zero = (bus.RegB_out == '0);
   assign a_mag  = a_neg ? -bus.RegA_out : bus.RegA_out;
   assign b_mag  = b_neg ? -bus.RegB_out : bus.RegB_out;

   // Booth add/sub of the multiplicand, and the restoring trial subtract
   always_comb begin
      booth_sum = acc_q;
      unique case ({q_q[0], qm1_q})
         2'b01:   booth_sum = acc_q + m_q;
         2'b10:   booth_sum = acc_q - m_q;
         default: booth_sum = acc_q;
      endcase
   end

   assign shl  = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign diff = shl - m_q;

   // MULTU ran Booth on a signed multiplier; add M<<WIDTH back when its MSB was set
   assign mul_hi = acc_q[WIDTH-1:0] + (fixb_q ? m_q[WIDTH-1:0] : '0);
   assign div_lo = fixa_q ? -q_q : q_q;
   assign div_hi = fixb_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      cnt_d   = cnt_q;
      fixa_d  = fixa_q;
      fixb_d  = fixb_q;
      dz_d    = dz_q;
      dbz_d   = dbz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      if (accept) begin
         op_d    = bus.op;
         cnt_d   = '0;
         qm1_d   = 1'b0;
         acc_d   = '0;
         dbz_d   = 1'b0;
         dz_d    = in_div & b_zero;
         state_d = (in_div & b_zero) ? FIN : CALC;
         if (in_div) begin
            m_d    = {1'b0, b_mag};
            q_d    = a_mag;
            fixa_d = a_neg ^ b_neg;
            fixb_d = a_neg;
         end else begin
            m_d    = {in_sgn & bus.RegA_out[WIDTH-1], bus.RegA_out};
            q_d    = bus.RegB_out;
            fixa_d = 1'b0;
            fixb_d = ~in_sgn & bus.RegB_out[WIDTH-1];
         end
      end

      unique case (state_q)
         IDLE: ;
         CALC: begin
            if (abort_w) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH-1)) state_d = FIN;
               if (op_q[1]) begin
                  if (diff[WIDTH]) begin
                     acc_d = shl;
                     q_d   = {q_q[WIDTH-2:0], 1'b0};
                  end else begin
                     acc_d = diff;
                     q_d   = {q_q[WIDTH-2:0], 1'b1};
                  end
               end else begin
                  acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                  q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                  qm1_d = q_q[0];
               end
            end
         end
         FIN: begin
            done_d = 1'b1;
            if (!accept) state_d = IDLE;
            if (dz_q) begin
               dbz_d = 1'b1;
            end else if (op_q[1]) begin
               hi_d = div_hi;
               lo_d = div_lo;
            end else begin
               hi_d = mul_hi;
               lo_d = q_q;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == CALC) | ((state_d == FIN) & (state_q == CALC));
   end

   always_ff @(posedge clock) begin
      if (!Reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         fixa_q  <= 1'b0;
         fixb_q  <= 1'b0;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         cnt_q   <= cnt_d;
         fixa_q  <= fixa_d;
         fixb_q  <= fixb_d;
         dz_q    <= dz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.Hi             = hi_q;
   assign bus.Lo             = lo_q;
   assign bus.divide_by_zero = dbz_q;
endmodule
